// File: rtl/inst_defs.sv
// Shared encodings for the MEM/WB stage: write-back source selects and load/store funct3 codes.
package inst_defs;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    logic half;
    half = (funct3 == F3_H) || (funct3 == F3_HU);
    return (half && lo[0]) || ((funct3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_memory.sv
// DEPTH x 32 single-port data memory with byte write enables and a registered read; no reset.
module data_memory #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_writeback_pipe.sv
// Combined MEM/WB stage: store lane steering, synchronous data memory, load extraction, WB mux.
// Optional misaligned-access detection is enabled by defining MISALIGNED_DETECT_EN.
module memory_writeback_pipe
  import inst_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result_EXMEM,
  input  logic [WIDTH-1:0] rs2_data_EXMEM,
  input  logic [2:0]       funct3_EXMEM,
  input  logic             mem_wr_en_EXMEM,
  input  logic             reg_wr_en_EXMEM,
  input  logic [1:0]       reg_wr_ctrl_EXMEM,
  input  logic [4:0]       rd_EXMEM,
  input  logic [WIDTH-1:0] pc_4_EXMEM,
  output logic [WIDTH-1:0] reg_wr_data_WBID,
  output logic [4:0]       rd_WBID,
  output logic             reg_wr_en_WBID,
  output logic [WIDTH-1:0] fwd_data_MEM,
  output logic [4:0]       fwd_rd_MEM,
  output logic             fwd_en_MEM,
  output logic             misaligned_WB
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]       lo;
  logic             mis_mem;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      raw;

  logic             wb_en_q;
  logic [4:0]       rd_q;
  logic [1:0]       ctrl_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] pc4_q;
  logic             mis_q;

  assign lo = alu_result_EXMEM[1:0];

`ifdef MISALIGNED_DETECT_EN
  logic is_mem_access;
  assign is_mem_access = mem_wr_en_EXMEM || (reg_wr_ctrl_EXMEM == WB_MEM);
  assign mis_mem       = is_mem_access && is_misaligned(funct3_EXMEM, lo);
`else
  assign mis_mem = 1'b0;
`endif

  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    if (mem_wr_en_EXMEM && !reset && !mis_mem) begin
      case (funct3_EXMEM)
        F3_B: begin
          be    = 4'b0001 << lo;
          wdata = {4{rs2_data_EXMEM[7:0]}};
        end
        F3_H: begin
          be    = lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{rs2_data_EXMEM[15:0]}};
        end
        F3_W: begin
          be    = 4'b1111;
          wdata = rs2_data_EXMEM;
        end
        default: ;
      endcase
    end
  end

  data_memory #(
    .DEPTH(DEPTH)
  ) u_data_memory (
    .clk  (clk),
    .addr (alu_result_EXMEM[AW+1:2]),
    .be   (be),
    .wdata(wdata),
    .rdata(raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_q <= 1'b0;
      rd_q    <= '0;
      ctrl_q  <= WB_ALU;
      f3_q    <= '0;
      lo_q    <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      wb_en_q <= reg_wr_en_EXMEM;
      rd_q    <= rd_EXMEM;
      ctrl_q  <= reg_wr_ctrl_EXMEM;
      f3_q    <= funct3_EXMEM;
      lo_q    <= lo;
      alu_q   <= alu_result_EXMEM;
      pc4_q   <= pc_4_EXMEM;
      mis_q   <= mis_mem;
    end
  end

  logic [31:0] byte_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_shift = raw >> {lo_q, 3'b000};
    byte_sel   = byte_shift[7:0];
    half_sel   = lo_q[1] ? raw[31:16] : raw[15:0];
    case (f3_q)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = raw;
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    case (ctrl_q)
      WB_MEM:  reg_wr_data_WBID = load_data;
      WB_PC4:  reg_wr_data_WBID = pc4_q;
      default: reg_wr_data_WBID = alu_q;
    endcase
  end

  assign rd_WBID        = rd_q;
  assign reg_wr_en_WBID = wb_en_q && (rd_q != 5'd0) && !(mis_q && (ctrl_q == WB_MEM));
`ifdef MISALIGNED_DETECT_EN
  assign misaligned_WB  = mis_q;
`else
  assign misaligned_WB  = 1'b0;
`endif

  // Load data is not available until WB, so loads never forward from MEM.
  assign fwd_en_MEM   = reg_wr_en_EXMEM && (rd_EXMEM != 5'd0) && (reg_wr_ctrl_EXMEM != WB_MEM);
  assign fwd_data_MEM = (reg_wr_ctrl_EXMEM == WB_PC4) ? pc_4_EXMEM : alu_result_EXMEM;
  assign fwd_rd_MEM   = rd_EXMEM;

endmodule
